piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out stage sitting directly downstream of the PIPO shift
//   register: accepts its WIDTH-bit parallel word (pout) via valid/ready and
//   shifts it out one bit per clock with a bit-valid strobe and last-bit flag.
//   Back-to-back words stream with zero idle cycles between them.
// PARAMETERS
//   WIDTH      4   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk        in   1      rising-edge clock; the block's only clock
//   rst_n      in   1      asynchronous, active-low reset
//   pin        in   WIDTH  parallel word, typically the PIPO register's pout
//   pin_valid  in   1      pin holds a word to transfer
//   pin_ready  out  1      block can take a word at this edge
//   sout       out  1      serial data bit
//   sout_valid out  1      sout carries a real bit this cycle
//   sout_last  out  1      current bit is the final bit of its word
//   busy       out  1      a word is being shifted (state == SHIFT)
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, shift reg=0, bit count=0,
//     sout=0, sout_valid=0, sout_last=0, busy=0. pin_ready=1 (from IDLE),
//     but no transfer happens while rst_n is low. Leaving reset is synchronous
//     to the next clk edge.
//   Transfer: occurs at a rising edge where pin_valid && pin_ready. The word is
//     copied into an internal shift register; later changes on pin do not
//     affect the word. Upstream holds pin/pin_valid stable until accepted.
//   States:
//     IDLE : pin_ready=1, sout_valid=0. Transfer -> SHIFT, cnt=0.
//     SHIFT: sout_valid=1, busy=1; each edge shifts one bit out and does cnt+1.
//            When cnt==WIDTH-1: sout_last=1 and pin_ready=1.
//            A transfer at that edge -> stay in SHIFT, cnt=0, new word loaded.
//            No transfer at that edge -> IDLE.
//            When cnt<WIDTH-1: pin_ready=0.
//   pin_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). It is
//     combinational from registered state only, with no path from pin_valid.
//   sout, sout_valid, sout_last and busy come straight from registers
//     (shift-reg end bit, state, cnt), with no combinational input path.
//   Latency: a word accepted at edge k puts its first bit on sout in the
//     cycle after edge k. Its last bit is in the cycle after edge k+WIDTH-1.
//   Bit order: MSB_FIRST=1 shifts left and sends reg[WIDTH-1].
//     MSB_FIRST=0 shifts right and sends reg[0]. The vacated bit fills with 0.
//   Counter width is $clog2(WIDTH). It never exceeds WIDTH-1; reaching the end
//     reloads it to 0 or returns to IDLE, so it never wraps on its own.
//   Throughput: one word per WIDTH cycles when pin_valid is held high.
//   Reset mid-SHIFT: the word is dropped at once and outputs go to reset values.
//     After release, the next transfer starts a fresh word at cnt=0.
//   pin_valid high while pin_ready is low: no effect, nothing is lost.
//     The transfer happens at the first edge where pin_ready is high.
// TESTING (WIDTH=4 unless noted)
//   1 Reset then pin=4'b1010 valid 1 cycle -> next 4 cycles sout=1,0,1,0,
//     sout_valid=1111, sout_last on 4th only, then IDLE, sout_valid=0.
//   2 pin_valid held high with 1100 then 1111 (changes on accept) ->
//     8 contiguous valid bits 1,1,0,0,1,1,1,1, sout_last on bits 4 and 8,
//     pin_ready high only in IDLE and on the bit-4 cycle.
//   3 pin=0101 presented while busy mid-word -> not taken until the cycle
//     where cnt==3; its first bit follows the prior last bit with no gap.
//   4 rst_n low asynchronously during bit 2 of 1010 -> outputs go to 0
//     immediately (no clk edge needed). After release pin=0011 -> 0,0,1,1.
//   5 MSB_FIRST=0, pin=4'b1000 -> sout=0,0,0,1, last on 4th.
//   6 WIDTH=8, pin=8'hA5 -> sout=1,0,1,0,0,1,0,1, sout_last on bit 8 only.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out stage. Takes a WIDTH-bit word over a valid/ready
//   handshake and shifts it out one bit per clock, with a bit-valid strobe
//   and a last-bit flag. A new word can be taken on the last-bit cycle of the
//   previous one, so back-to-back words stream with no idle cycles.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   pin        parallel word to serialize
//   pin_valid  pin holds a word to transfer
//   pin_ready  a word can be taken at this edge
//   sout       serial data bit
//   sout_valid sout carries a real bit this cycle
//   sout_last  current bit is the final bit of its word
//   busy       a word is being shifted
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             at_end;
  logic             take;

  // Move the register one place toward the output end, filling with 0.
  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] r);
    if (MSB_FIRST) shifted = {r[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, r[WIDTH-1:1]};
  endfunction

  // pin_ready depends only on registered state, never on pin_valid.
  assign at_end    = (state == SHIFT) && (cnt == CNT_LAST);
  assign pin_ready = (state == IDLE) || at_end;
  assign take      = pin_valid && pin_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    case (state)
      IDLE: begin
        if (take) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          sreg_nx  = pin;
        end
      end
      SHIFT: begin
        if (at_end) begin
          cnt_nx = '0;
          if (take) begin
            sreg_nx = pin;
          end else begin
            state_nx = IDLE;
            // Shift the final bit out too, so the register idles at zero.
            sreg_nx  = shifted(sreg);
          end
        end else begin
          cnt_nx  = cnt + CW'(1);
          sreg_nx = shifted(sreg);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sreg_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
    end
  end

  // All serial-side outputs are taken straight from registers.
  assign sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign sout_last  = at_end;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic clk;
  logic rst_n;
  int   cyc;

  // d=0: WIDTH=4 MSB first; d=1: WIDTH=4 LSB first; d=2: WIDTH=8 MSB first
  logic [3:0] pin_a, pin_b;
  logic [7:0] pin_c;
  logic       v_a, v_b, v_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       so_a, so_b, so_c;
  logic       sv_a, sv_b, sv_c;
  logic       sl_a, sl_b, sl_c;
  logic       bz_a, bz_b, bz_c;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .pin(pin_a), .pin_valid(v_a), .pin_ready(rdy_a),
    .sout(so_a), .sout_valid(sv_a), .sout_last(sl_a), .busy(bz_a));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .pin(pin_b), .pin_valid(v_b), .pin_ready(rdy_b),
    .sout(so_b), .sout_valid(sv_b), .sout_last(sl_b), .busy(bz_b));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .pin(pin_c), .pin_valid(v_c), .pin_ready(rdy_c),
    .sout(so_c), .sout_valid(sv_c), .sout_last(sl_c), .busy(bz_c));

  int total  = 0;
  int passed = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic mon_bit(input string name, input logic so, input logic sl,
                         inout logic [1:0] q[$]);
    logic [1:0] e;
    if (q.size() == 0) begin
      check({name, " unexpected bit"}, 1, 0);
    end else begin
      e = q.pop_front();
      check({name, " sout"}, int'(so), int'(e[1]));
      check({name, " sout_last"}, int'(sl), int'(e[0]));
    end
  endtask

  // Monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) q_a.delete();
    else if (sv_a) mon_bit("a", so_a, sl_a, q_a);
  end
  always @(negedge clk) begin
    if (!rst_n) q_b.delete();
    else if (sv_b) mon_bit("b", so_b, sl_b, q_b);
  end
  always @(negedge clk) begin
    if (!rst_n) q_c.delete();
    else if (sv_c) mon_bit("c", so_c, sl_c, q_c);
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       rdy = rdy_a;
      1:       rdy = rdy_b;
      default: rdy = rdy_c;
    endcase
  endfunction

  function automatic logic bsy(input int d);
    case (d)
      0:       bsy = bz_a;
      1:       bsy = bz_b;
      default: bsy = bz_c;
    endcase
  endfunction

  // Present word w; e is the hand-computed serial sequence, first bit at e[n-1].
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic [7:0] w, input logic [7:0] e,
                      output int waits, output int tacc);
    int n;
    n = (d == 2) ? 8 : 4;
    for (int i = n - 1; i >= 0; i--) begin
      case (d)
        0:       q_a.push_back({e[i], (i == 0)});
        1:       q_b.push_back({e[i], (i == 0)});
        default: q_c.push_back({e[i], (i == 0)});
      endcase
    end
    case (d)
      0:       begin pin_a = w[3:0]; v_a = 1'b1; end
      1:       begin pin_b = w[3:0]; v_b = 1'b1; end
      default: begin pin_c = w;      v_c = 1'b1; end
    endcase
    waits = 0;
    while (!rdy(d)) begin
      waits++;
      if (waits > 20) begin
        check("pin_ready timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    tacc = cyc;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (bsy(d)) begin
      n++;
      if (n > 30) begin
        check("busy timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int w1, t1, w2, t2;

  initial begin
    cyc   = 0;
    rst_n = 1'b0;
    pin_a = '0; pin_b = '0; pin_c = '0;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    #1;
    check("reset sout", int'(so_a), 0);
    check("reset sout_valid", int'(sv_a), 0);
    check("reset sout_last", int'(sl_a), 0);
    check("reset busy", int'(bz_a), 0);
    check("reset pin_ready", int'(rdy_a), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single word 1010
    send(0, 8'h0A, 8'h0A, w1, t1);
    check("t1 accept waits", w1, 0);
    check("t1 busy after accept", int'(bz_a), 1);
    check("t1 ready mid-word", int'(rdy_a), 0);
    wait_idle(0);
    check("t1 idle sout_valid", int'(sv_a), 0);
    check("t1 idle pin_ready", int'(rdy_a), 1);
    check("t1 elapsed cycles", cyc - t1, 4);

    // 2: back-to-back 1100 then 1111
    send(0, 8'h0C, 8'h0C, w1, t1);
    send(0, 8'h0F, 8'h0F, w2, t2);
    check("t2 ready-low cycles", w2, 3);
    check("t2 accept spacing", t2 - t1, 4);
    wait_idle(0);
    check("t2 contiguous span", cyc - t1, 8);

    // 3: 0101 presented one cycle into a busy word
    send(0, 8'h09, 8'h09, w1, t1);
    @(posedge clk); #1;
    send(0, 8'h05, 8'h05, w2, t2);
    check("t3 ready-low cycles", w2, 2);
    check("t3 accept spacing", t2 - t1, 4);
    wait_idle(0);
    check("t3 contiguous span", cyc - t1, 8);

    // 4: async reset during bit 2 of 1010
    send(0, 8'h0A, 8'h0A, w1, t1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t4 async sout", int'(so_a), 0);
    check("t4 async sout_valid", int'(sv_a), 0);
    check("t4 async sout_last", int'(sl_a), 0);
    check("t4 async busy", int'(bz_a), 0);
    check("t4 ready in reset", int'(rdy_a), 1);
    pin_a = 4'hF; v_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 v_a = 1'b0;
    check("t4 no transfer in reset", int'(bz_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t4 idle after release", int'(sv_a), 0);
    send(0, 8'h03, 8'h03, w1, t1);
    wait_idle(0);

    // 5: LSB first, 1000 -> 0,0,0,1
    send(1, 8'h08, 8'h01, w1, t1);
    wait_idle(1);
    check("t5 elapsed cycles", cyc - t1, 4);

    // 6: WIDTH=8, A5 -> 1,0,1,0,0,1,0,1
    send(2, 8'hA5, 8'hA5, w1, t1);
    check("t6 ready mid-word", int'(rdy_c), 0);
    wait_idle(2);
    check("t6 elapsed cycles", cyc - t1, 8);

    repeat (3) @(posedge clk);
    #1;
    check("queue a drained", q_a.size(), 0);
    check("queue b drained", q_b.size(), 0);
    check("queue c drained", q_c.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
